// File: rtl/rv32i_types_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types_pkg
//   Shared vector-datapath types.
//   NUM_LANES    : number of execution lanes fed per element group.
//   offset_t     : element index produced by the vector element counter.
//   lane_issue_t : one issue-buffer entry (group offset, per-lane active bits,
//                  last-group flag).
// ---------------------------------------------------------------------------
package rv32i_types_pkg;

    localparam int NUM_LANES = 2;

    typedef logic [31:0] offset_t;

    typedef struct packed {
        offset_t                offset;
        logic [NUM_LANES-1:0]   lane_en;
        logic                   last;
    } lane_issue_t;

endpackage

// File: rtl/vec_lane_issue_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vec_lane_issue_buffer_pkg
//   Local constants and helpers for the lane issue buffer.
//   CMP_W     : width of the element index comparisons (one guard bit above
//               the 32-bit offset so offset + lane never wraps).
//   MASK_BITS : number of bits in the v0 mask register (VEC_LANE_MASK_EN).
//   is_pow2   : elaboration-time check for the FIFO depth.
// ---------------------------------------------------------------------------
package vec_lane_issue_buffer_pkg;

    localparam int CMP_W     = 33;
    localparam int MASK_BITS = 32;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vec_lane_issue_buffer_if.sv
// ---------------------------------------------------------------------------
// vec_lane_issue_buffer_if
//   Bundles the counter-side push interface, the lane-side pop interface and
//   the status signals of vec_lane_issue_buffer.
//   master : element counter / lanes side (drives clear, in_*, vstart, vl,
//            out_ready; observes stall_out, out_*, occupancy, busy).
//   slave  : the issue buffer itself.
//   Optional macro VEC_LANE_MASK_EN adds vmask (v0) and vm (1 = unmasked).
//
// Handshakes:
//   Push side: an offset is taken on a rising clock edge when in_valid is high
//   and stall_out is low; with stall_out high in_valid is ignored and the
//   counter must hold in_offset.  Pop side: the head entry leaves on a rising
//   clock edge when out_valid and out_ready are both high; out_ready while
//   out_valid is low has no effect.  out_* stay stable until popped.
// ---------------------------------------------------------------------------
interface vec_lane_issue_buffer_if
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                         clear;
    logic                         in_valid;
    offset_t                      in_offset;
    logic                         in_last;
    logic [31:0]                  vstart;
    logic [31:0]                  vl;
`ifdef VEC_LANE_MASK_EN
    logic [31:0]                  vmask;
    logic                         vm;
`endif
    logic                         stall_out;
    logic                         out_valid;
    logic                         out_ready;
    offset_t                      out_offset;
    logic [NUM_LANES-1:0]         out_lane_en;
    logic                         out_last;
    logic [$clog2(DEPTH):0]       occupancy;
    logic                         busy;

    modport master (
`ifdef VEC_LANE_MASK_EN
        output vmask,
        output vm,
`endif
        output clear,
        output in_valid,
        output in_offset,
        output in_last,
        output vstart,
        output vl,
        output out_ready,
        input  stall_out,
        input  out_valid,
        input  out_offset,
        input  out_lane_en,
        input  out_last,
        input  occupancy,
        input  busy
    );

    modport slave (
`ifdef VEC_LANE_MASK_EN
        input  vmask,
        input  vm,
`endif
        input  clear,
        input  in_valid,
        input  in_offset,
        input  in_last,
        input  vstart,
        input  vl,
        input  out_ready,
        output stall_out,
        output out_valid,
        output out_offset,
        output out_lane_en,
        output out_last,
        output occupancy,
        output busy
    );

endinterface

// File: rtl/vec_lane_issue_buffer_en_gen.sv
// ---------------------------------------------------------------------------
// vec_lane_en_gen
//   Combinational per-lane active enables for one element group.
//   offset_i  : first element index of the group.
//   vstart_i  : first element to execute (prestart masking).
//   vl_i      : vector length (tail masking; vl == 0 disables every lane).
//   vmask_i   : v0 mask register        (only with VEC_LANE_MASK_EN).
//   vm_i      : 1 = unmasked operation  (only with VEC_LANE_MASK_EN).
//   lane_en_o : bit i set when element offset_i + i is active.
// ---------------------------------------------------------------------------
module vec_lane_en_gen
    import rv32i_types_pkg::*;
    import vec_lane_issue_buffer_pkg::*;
(
    input  offset_t              offset_i,
    input  logic [31:0]          vstart_i,
    input  logic [31:0]          vl_i,
`ifdef VEC_LANE_MASK_EN
    input  logic [31:0]          vmask_i,
    input  logic                 vm_i,
`endif
    output logic [NUM_LANES-1:0] lane_en_o
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        // Element index carried in 33 bits so an offset near 2^32 compares
        // as a large number instead of wrapping to a small one.
        logic [CMP_W-1:0] elem;
        logic             in_body;

        assign elem    = {1'b0, offset_i} + CMP_W'(g);
        assign in_body = (elem >= {1'b0, vstart_i}) && (elem < {1'b0, vl_i});

`ifdef VEC_LANE_MASK_EN
        // Elements beyond the 32-bit mask register count as masked off.
        logic mask_ok;
        assign mask_ok      = vm_i || ((elem < CMP_W'(MASK_BITS)) && vmask_i[elem[4:0]]);
        assign lane_en_o[g] = in_body && mask_ok;
`else
        assign lane_en_o[g] = in_body;
`endif
    end

endmodule

// File: rtl/vec_lane_issue_buffer.sv
// ---------------------------------------------------------------------------
// vec_lane_issue_buffer
//   Captures each element-group offset from the vector element counter,
//   attaches per-lane active enables (prestart/tail, optionally v0 mask) and
//   queues the result in a DEPTH-entry FIFO feeding the execution lanes.
//   Ports:
//     CLK  : system clock.
//     nRST : asynchronous active-low reset.
//     bus  : vec_lane_issue_buffer_if.slave (clear, push side in_*, vstart,
//            vl, pop side out_*, stall_out, occupancy, busy).
//   Parameter DEPTH : FIFO entries, power of two, at least 2.
//   Optional macro VEC_LANE_MASK_EN : adds v0 mask qualification of lanes.
//   Head outputs come straight from entry registers: an entry pushed into an
//   empty FIFO is visible one cycle later (no bypass path).
// ---------------------------------------------------------------------------
module vec_lane_issue_buffer
    import rv32i_types_pkg::*;
    import vec_lane_issue_buffer_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     CLK,
    input  logic                     nRST,
    vec_lane_issue_buffer_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("vec_lane_issue_buffer: DEPTH must be a power of two and at least 2");
    end

    lane_issue_t              mem_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]         occ_q, occ_d;

    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic [NUM_LANES-1:0]     lane_en;
    lane_issue_t              push_entry;
    lane_issue_t              head;

    vec_lane_en_gen u_lane_en (
        .offset_i  (bus.in_offset),
        .vstart_i  (bus.vstart),
        .vl_i      (bus.vl),
`ifdef VEC_LANE_MASK_EN
        .vmask_i   (bus.vmask),
        .vm_i      (bus.vm),
`endif
        .lane_en_o (lane_en)
    );

    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);

    // clear wins over both sides; an all-inactive entry is still pushed so
    // the last flag always reaches the lanes.
    assign push = bus.in_valid && !full && !bus.clear;
    assign pop  = !empty && bus.out_ready && !bus.clear;

    assign push_entry.offset  = bus.in_offset;
    assign push_entry.lane_en = lane_en;
    assign push_entry.last    = bus.in_last;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by occ_q alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Head fields are forced to zero while empty so stale or unreset entry
    // contents never reach the lanes.
    assign bus.out_valid   = !empty;
    assign bus.out_offset  = empty ? '0 : head.offset;
    assign bus.out_lane_en = empty ? '0 : head.lane_en;
    assign bus.out_last    = empty ? 1'b0 : head.last;
    assign bus.stall_out   = full;
    assign bus.occupancy   = occ_q;
    assign bus.busy        = !empty || bus.in_valid;

endmodule

// File: tb/tb_vec_lane_issue_buffer.sv
// ---------------------------------------------------------------------------
// tb_vec_lane_issue_buffer
//   Self-checking bench for vec_lane_issue_buffer (DEPTH = 4, NUM_LANES = 2).
//   Directed scenarios followed by a randomized run, all checked against a
//   queue model whose lane enables are computed from the element rules with
//   64-bit integer arithmetic.  Works with or without VEC_LANE_MASK_EN.
// ---------------------------------------------------------------------------
module tb_vec_lane_issue_buffer;
    import rv32i_types_pkg::*;

    localparam int DEPTH  = 4;
    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int ENT_W  = 32 + NUM_LANES + 1;
    localparam int VIEW_W = 1 + ENT_W + OCC_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    vec_lane_issue_buffer_if #(.DEPTH(DEPTH)) bus ();

    vec_lane_issue_buffer #(.DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.slave)
    );

    // ---------------- scoreboard ----------------
    logic [ENT_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Element e is active when vstart <= e < vl (and, when masked, e < 32 with
    // its v0 bit set). 64-bit arithmetic keeps offset + lane from wrapping.
    function automatic logic [NUM_LANES-1:0] ref_lanes(input logic [31:0] off);
        logic [NUM_LANES-1:0] r;
        longint e;
        bit on;
        r = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            e  = longint'({32'b0, off}) + longint'(i);
            on = (e >= longint'({32'b0, bus.vstart})) && (e < longint'({32'b0, bus.vl}));
`ifdef VEC_LANE_MASK_EN
            if (!bus.vm) begin
                on = on && (e < 32) && bus.vmask[e[4:0]];
            end
`endif
            r[i] = on;
        end
        return r;
    endfunction

    function automatic logic [VIEW_W-1:0] exp_view();
        if (exp_q.size() == 0) return '0;
        return {1'b1, exp_q[0], OCC_W'(exp_q.size())};
    endfunction

    function automatic logic [VIEW_W-1:0] dut_view();
        return {bus.out_valid, bus.out_offset, bus.out_lane_en, bus.out_last, bus.occupancy};
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle from just after a falling edge, updates the model at
    // the rising edge, and returns at the next falling edge (sample point).
    task automatic drive_cycle(input logic v, input logic [31:0] off, input logic last,
                               input logic rdy, input logic clr);
        logic [ENT_W-1:0] ent;
        bit was_full;
        bit do_pop;
        bus.in_valid  = v;
        bus.in_offset = off;
        bus.in_last   = last;
        bus.out_ready = rdy;
        bus.clear     = clr;
        ent      = {off, ref_lanes(off), last};
        was_full = (exp_q.size() == DEPTH);
        do_pop   = (exp_q.size() > 0) && rdy;
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (v && !was_full) exp_q.push_back(ent);
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.in_valid  = 1'b0;
        bus.in_offset = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nrst = 1'b0;
        set_idle();
        bus.vstart = '0;
        bus.vl     = '0;
`ifdef VEC_LANE_MASK_EN
        bus.vm    = 1'b1;
        bus.vmask = '0;
`endif
        #12;
        checks++;
        if (dut_view() !== VIEW_W'(0)) begin
            errors++;
            $display("FAIL reset_view got %h exp %h", dut_view(), VIEW_W'(0));
        end
        checks++;
        if ({bus.stall_out, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall_busy got %b exp 00", {bus.stall_out, bus.busy});
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [NUM_LANES-1:0] want [3];
        logic [31:0] offs [3];
        want[0] = 2'b11; want[1] = 2'b11; want[2] = 2'b01;
        offs[0] = 0;     offs[1] = 2;     offs[2] = 4;
        bus.vstart = 0;
        bus.vl     = 5;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, offs[k], (k == 2), 1'b1, 1'b0);
            checks++;
            if (dut_view() !== exp_view()) begin
                errors++;
                $display("FAIL basic_view[%0d] got %h exp %h", k, dut_view(), exp_view());
            end
            checks++;
            if ({bus.out_valid, bus.out_offset, bus.out_lane_en, bus.out_last} !== {1'b1, offs[k], want[k], (k == 2)}) begin
                errors++;
                $display("FAIL basic_head[%0d] got v=%b off=%0d en=%b last=%b exp v=1 off=%0d en=%b last=%b",
                         k, bus.out_valid, bus.out_offset, bus.out_lane_en, bus.out_last, offs[k], want[k], (k == 2));
            end
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL basic_drain got %h exp %h", dut_view(), exp_view());
        end
        set_idle();
    endtask

    task automatic test_prestart();
        bus.vstart = 3;
        bus.vl     = 6;
        drive_cycle(1'b1, 2, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.out_lane_en !== 2'b10 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL prestart_off2 got %h exp %h (lane_en want 10)", dut_view(), exp_view());
        end
        drive_cycle(1'b1, 4, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.out_lane_en !== 2'b11 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL prestart_off4 got %h exp %h (lane_en want 11)", dut_view(), exp_view());
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        set_idle();
    endtask

    task automatic test_full();
        bus.vstart = 0;
        bus.vl     = 8;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 2 * k, 1'b0, 1'b0, 1'b0);
            checks++;
            if (dut_view() !== exp_view() || bus.stall_out !== (k == 3)) begin
                errors++;
                $display("FAIL full_fill[%0d] got %h stall=%b exp %h stall=%b",
                         k, dut_view(), bus.stall_out, exp_view(), (k == 3));
            end
        end
        drive_cycle(1'b1, 8, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.occupancy !== OCC_W'(4) || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL full_drop got %h exp %h", dut_view(), exp_view());
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.occupancy !== OCC_W'(3) || bus.stall_out !== 1'b0 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL full_release got %h stall=%b exp %h stall=0", dut_view(), bus.stall_out, exp_view());
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        // Entering with offsets 2,4,6 queued.
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 10, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.occupancy !== OCC_W'(2) || bus.out_offset !== 32'd6 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL b2b_occ2 got %h exp %h", dut_view(), exp_view());
        end
        drive_cycle(1'b1, 12, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 14, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 16, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.occupancy !== OCC_W'(3) || bus.out_offset !== 32'd10 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL b2b_full_pop got %h exp %h", dut_view(), exp_view());
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_view() !== exp_view()) begin
                errors++;
                $display("FAIL b2b_drain[%0d] got %h exp %h", k, dut_view(), exp_view());
            end
        end
        set_idle();
    endtask

    task automatic test_clear();
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, k, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.occupancy !== OCC_W'(3)) begin
            errors++;
            $display("FAIL clear_pre got occ=%0d exp 3", bus.occupancy);
        end
        drive_cycle(1'b1, 6, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.occupancy !== OCC_W'(0) || bus.out_valid !== 1'b0 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL clear_post got %h exp %h", dut_view(), exp_view());
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        bus.vl = 8;
        drive_cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 2, 1'b0, 1'b0, 1'b0);
        set_idle();
        #2;
        nrst = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (dut_view() !== VIEW_W'(0) || bus.stall_out !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %h stall=%b busy=%b exp 0", dut_view(), bus.stall_out, bus.busy);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL reset_mid_release got %h exp %h", dut_view(), exp_view());
        end
    endtask

    task automatic test_vl_zero();
        bus.vstart = 0;
        bus.vl     = 0;
        drive_cycle(1'b1, 0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_lane_en, bus.out_last} !== 4'b1001 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL vl_zero got %h exp %h (valid=1 en=00 last=1)", dut_view(), exp_view());
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        set_idle();
    endtask

`ifdef VEC_LANE_MASK_EN
    task automatic test_mask();
        bus.vstart = 0;
        bus.vl     = 2;
        bus.vm     = 1'b0;
        bus.vmask  = 32'h1;
        drive_cycle(1'b1, 0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.out_lane_en !== 2'b01 || dut_view() !== exp_view()) begin
            errors++;
            $display("FAIL mask_v0 got %h exp %h (lane_en want 01)", dut_view(), exp_view());
        end
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        bus.vm = 1'b1;
        set_idle();
    endtask
`endif

    task automatic test_random();
        logic [31:0] off;
        for (int n = 0; n < 600; n++) begin
            if (n % 25 == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.vstart = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                    bus.vl     = 32'hFFFF_FFFF - $urandom_range(0, 1);
                end else begin
                    bus.vstart = $urandom_range(0, 10);
                    bus.vl     = $urandom_range(0, 40);
                end
`ifdef VEC_LANE_MASK_EN
                bus.vm    = $urandom_range(0, 1);
                bus.vmask = $urandom;
`endif
            end
            if ($urandom_range(0, 3) == 0) off = 32'hFFFF_FFFF - $urandom_range(0, 20);
            else                           off = $urandom_range(0, 40);
            drive_cycle($urandom_range(0, 2) != 0, off, $urandom_range(0, 1),
                        $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
            checks++;
            if (dut_view() !== exp_view() || bus.stall_out !== (exp_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL random[%0d] got %h stall=%b exp %h stall=%b",
                         n, dut_view(), bus.stall_out, exp_view(), (exp_q.size() == DEPTH));
            end
            checks++;
            if (bus.busy !== ((exp_q.size() != 0) || bus.in_valid)) begin
                errors++;
                $display("FAIL random_busy[%0d] got %b exp %b", n, bus.busy, ((exp_q.size() != 0) || bus.in_valid));
            end
        end
        set_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_prestart();
        test_full();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_vl_zero();
`ifdef VEC_LANE_MASK_EN
        test_mask();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_lane_issue_buffer.md
Name: vec_lane_issue_buffer

Overview:
- Sits directly downstream of the vector element counter.
- Each cycle the counter advances, this block captures the element offset and computes per-lane active enables from vstart/vl (tail and prestart masking).
- It queues the resulting issue entries in a small FIFO and hands them to the execution lanes over a valid/ready handshake.
- It back-pressures the counter through its stall input when full.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- NUM_LANES is not a parameter; it is taken from rv32i_types_pkg (current value 2).

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush; same signal the counter receives.
- in_valid  input  1  counter has a new offset (counter enabled and not stalled).
- in_offset  input  offset_t  first element index of this group.
- in_last  input  1  counter done for this group.
- vstart  input  32  first element to execute.
- vl  input  32  vector length.
- stall_out  output  1  back-pressure to the counter; equals full.
- out_valid  output  1  head entry present.
- out_ready  input  1  lanes accept the head entry this cycle.
- out_offset  output  offset_t  head entry offset.
- out_lane_en  output  NUM_LANES  per-lane active bits of the head entry.
- out_last  output  1  head entry is the final group of the instruction.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.
- busy  output  1  occupancy nonzero or in_valid asserted.

Behaviour:
- Reset: all outputs 0; pointers and occupancy 0; entry storage need not be reset.
- Lane enable, computed at push:
  - lane i is active when (in_offset + i >= vstart) and (in_offset + i < vl).
  - Both comparisons are done at 33 bits so in_offset + i never wraps.
  - vl == 0 gives all lanes inactive.
- Push: accepted when in_valid & ~full. An entry is pushed even when all its lanes are inactive, so that out_last is always delivered.
- Pop: occurs when out_valid & out_ready.
- Outputs: out_* are registered FIFO head contents. Latency from accepted push to out_valid is 1 cycle when the FIFO is empty (no bypass).
- Simultaneous push and pop:
  - When not full, both occur and occupancy is unchanged.
  - When full, the push is refused because stall_out is already high; the pop proceeds.
  - When empty, only the push occurs; the new entry appears at the head the next cycle.
- full = (occupancy == DEPTH); stall_out = full, purely combinational from state.
- Pointers: wrap modulo DEPTH. occupancy increments by 1 on push only, decrements by 1 on pop only.
- clear:
  - Has priority over push and pop in the same cycle.
  - Empties the FIFO, zeroes pointers and occupancy, and drops out_valid the next cycle.
- in_valid while stall_out is high: the input is ignored. The counter is expected to hold in_offset stable; the block has no internal holding register.
- out_ready with out_valid low: no effect.
- Reset asserted mid-operation: contents are discarded immediately (asynchronous); out_valid = 0.
- Illegal: DEPTH not a power of two; detected by an elaboration-time assertion.

Optional Feature:
- Macro: VEC_LANE_MASK_EN.
- With the macro:
  - Adds input vmask (32 bits, the v0 mask register) and input vm (1 = unmasked).
  - When vm = 0, lane i additionally requires vmask[in_offset + i] = 1. The index is taken modulo 32; elements at offsets of 32 or more are treated as masked off.
  - Mask bits are sampled at push time.
- Without the macro: vmask and vm are absent and lane enable depends only on vstart and vl.

Decomposition:
- rv32i_types_pkg contains NUM_LANES and offset_t (already present).
- Add to the package a typedef lane_issue_t {offset_t offset; logic [NUM_LANES-1:0] lane_en; logic last;}.
- One sub-module, vec_lane_en_gen: combinational per-lane enable from offset, vstart, vl (and mask). It is instantiated once on the push side.
- The FIFO storage and pointers stay in the top module.

Test Plan (NUM_LANES = 2, DEPTH = 4):
- Basic: vl = 5, vstart = 0; push offsets 0, 2, 4 with last on offset 4; out_ready held 1 → entries leave with lane_en 11, 11, 01; out_last only on the third; each appears 1 cycle after its push.
- Prestart: vstart = 3, vl = 6; push offsets 2 and 4 → lane_en 10 then 11.
- Full/back-pressure: out_ready = 0; push 5 times → occupancy reaches 4 and stall_out = 1 after the fourth push; the fifth push is dropped. Assert out_ready for one cycle → occupancy 3, stall_out = 0.
- Simultaneous push and pop:
  - at occupancy 2 → occupancy stays 2 and entries stay in order.
  - at full with in_valid = 1 → pop only, occupancy 3.
- Flush/reset: occupancy 3, then clear with in_valid = 1 and out_ready = 1 → next cycle occupancy 0 and out_valid 0. Separately, assert nRST low mid-stream → outputs 0 immediately.
- Edge, vl = 0: push offset 0 with in_last = 1 → lane_en 00 and out_last = 1. With VEC_LANE_MASK_EN defined, vm = 0 and vmask = 32'h1, push offset 0 with vl = 2 → lane_en 01.
